alu_op_sequencer: RTL and testbench

Front-end issuer for the 32-bit ALU. Accepts operation requests over a valid/ready handshake and drives the ALU's operand and opcode inputs, holding them stable. Waits the per-opcode latency, which is longest for the iterative divider, then captures the 64-bit C result. Returns the result as HI/LO words with a zero flag over a second valid/ready handshake. Sits between the datapath control unit and the ALU/Z register.

---
 rtl/alu_op_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Issues one ALU operation at a time: latches operands, waits the opcode latency, returns HI/LO.
// Optional build macro ALU_SEQ_DIV0_CHK_EN rejects DIV with a zero divisor without issuing it.
module alu_op_sequencer #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned SIMPLE_LAT = 1,
  parameter int unsigned MUL_LAT    = 2,
  parameter int unsigned DIV_LAT    = 34
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [4:0]            req_opcode,
  input  logic [DATA_W-1:0]     req_a,
  input  logic [DATA_W-1:0]     req_b,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  output logic [4:0]            alu_opcode,
  output logic                  alu_start,
  input  logic [2*DATA_W-1:0]   alu_result,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_lo,
  output logic [DATA_W-1:0]     rsp_hi,
  output logic                  rsp_zero,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam int unsigned MulDivMax = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
  localparam int unsigned MaxLat    = (MulDivMax > SIMPLE_LAT) ? MulDivMax : SIMPLE_LAT;
  localparam int unsigned CntW      = $clog2(MaxLat) + 1;

  localparam logic [CntW-1:0] SimpleM1 = CntW'(SIMPLE_LAT - 1);
  localparam logic [CntW-1:0] MulM1    = CntW'(MUL_LAT - 1);
  localparam logic [CntW-1:0] DivM1    = CntW'(DIV_LAT - 1);

  localparam logic [4:0] OpMul = 5'b10011;
  localparam logic [4:0] OpDiv = 5'b10100;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [4:0]          alu_opcode_q, alu_opcode_d;
  logic                alu_start_q, alu_start_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_lo_q, rsp_lo_d, rsp_hi_q, rsp_hi_d;
  logic                rsp_zero_q, rsp_zero_d;
  logic                rsp_err_q, rsp_err_d;
  logic                busy_q, busy_d;

  logic                op_legal;
  logic                div_zero;
  logic [CntW-1:0]     lat_m1;

  assign op_legal = (req_opcode <= 5'b01011) ||
                    ((req_opcode >= 5'b01110) && (req_opcode <= 5'b10100));

`ifdef ALU_SEQ_DIV0_CHK_EN
  assign div_zero = (req_opcode == OpDiv) && (req_b == '0);
`else
  assign div_zero = 1'b0;
`endif

  always_comb begin
    if (req_opcode == OpDiv) begin
      lat_m1 = DivM1;
    end else if (req_opcode == OpMul) begin
      lat_m1 = MulM1;
    end else begin
      lat_m1 = SimpleM1;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_opcode_d = alu_opcode_q;
    alu_start_d  = 1'b0;
    rsp_valid_d  = rsp_valid_q;
    rsp_lo_d     = rsp_lo_q;
    rsp_hi_d     = rsp_hi_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          alu_a_d      = req_a;
          alu_b_d      = req_b;
          alu_opcode_d = req_opcode;
          if (!op_legal) begin
            state_d     = StResp;
            rsp_valid_d = 1'b1;
            rsp_lo_d    = '0;
            rsp_hi_d    = '0;
            rsp_zero_d  = 1'b1;
            rsp_err_d   = 1'b1;
          end else if (div_zero) begin
            state_d     = StResp;
            rsp_valid_d = 1'b1;
            rsp_lo_d    = '1;
            rsp_hi_d    = '1;
            rsp_zero_d  = 1'b0;
            rsp_err_d   = 1'b1;
          end else begin
            state_d     = StWait;
            cnt_d       = lat_m1;
            alu_start_d = 1'b1;
          end
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d     = StResp;
          rsp_valid_d = 1'b1;
          rsp_lo_d    = alu_result[DATA_W-1:0];
          rsp_hi_d    = alu_result[2*DATA_W-1:DATA_W];
          rsp_zero_d  = (alu_result == '0);
          rsp_err_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_opcode_q <= '0;
      alu_start_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_lo_q     <= '0;
      rsp_hi_q     <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_opcode_q <= alu_opcode_d;
      alu_start_q  <= alu_start_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_lo_q     <= rsp_lo_d;
      rsp_hi_q     <= rsp_hi_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_err_q    <= rsp_err_d;
      busy_q       <= busy_d;
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_opcode = alu_opcode_q;
  assign alu_start  = alu_start_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_lo     = rsp_lo_q;
  assign rsp_hi     = rsp_hi_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Table-driven bench for alu_op_sequencer with a response scoreboard queue.
// The bench plays the ALU: it drives alu_result with the value listed for each vector.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  req_opcode = '0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [31:0] alu_a, alu_b;
  logic [4:0]  alu_opcode;
  logic        alu_start;
  logic [63:0] alu_result = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_lo, rsp_hi;
  logic        rsp_zero, rsp_err, busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_op_sequencer dut (
    .clk        (clk),
    .clr        (clr),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_a      (req_a),
    .req_b      (req_b),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_start  (alu_start),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_lo     (rsp_lo),
    .rsp_hi     (rsp_hi),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] res;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        zero;
    logic        err;
    int          cyc;
    logic        start;
    int          hold;
    logic        junk;
  } vec_t;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        zero;
    logic        err;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];

  function automatic vec_t mk(logic [4:0] op, logic [31:0] a, logic [31:0] b, logic [63:0] res,
                              logic [31:0] lo, logic [31:0] hi, logic zero, logic err, int cyc,
                              logic start, int hold, logic junk);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.res = res; v.lo = lo; v.hi = hi; v.zero = zero;
    v.err = err; v.cyc = cyc; v.start = start; v.hold = hold; v.junk = junk;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_op(input vec_t v);
    int   k;
    exp_t e;
    k = 0;
    while (!req_ready && k < 50) begin
      @(posedge clk); #1; k++;
    end
    chk("req_ready_before_issue", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b1; req_opcode = v.op; req_a = v.a; req_b = v.b; alu_result = v.res;
    sb_q.push_back('{v.lo, v.hi, v.zero, v.err});
    @(posedge clk); #1;
    k = 1;
    chk("alu_start_first_cycle", alu_start, v.start);
    if (v.start) chk("alu_a_latched", alu_a, v.a);
    while (!rsp_valid && k < 200) begin
      @(negedge clk);
      if (v.junk) begin
        req_valid = 1'b1; req_a = ~v.a; req_b = 32'h5; req_opcode = 5'b00001;
      end else begin
        req_valid = 1'b0;
      end
      @(posedge clk); #1;
      k++;
      chk("alu_start_single_pulse", alu_start, 0);
      chk("req_ready_low_busy", req_ready, 0);
      if (v.start) begin
        chk("alu_a_hold", alu_a, v.a);
        chk("alu_b_hold", alu_b, v.b);
        chk("alu_opcode_hold", alu_opcode, v.op);
      end
    end
    chk("rsp_latency_cycles", k, v.cyc);
    chk("busy_in_resp", busy, 1);
    chk("req_ready_in_resp", req_ready, 0);
    if (sb_q.size() == 0) begin
      chk("scoreboard_nonempty", 0, 1);
    end else begin
      e = sb_q.pop_front();
      chk("rsp_lo", rsp_lo, e.lo);
      chk("rsp_hi", rsp_hi, e.hi);
      chk("rsp_zero", rsp_zero, e.zero);
      chk("rsp_err", rsp_err, e.err);
      for (int h = 0; h < v.hold; h++) begin
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("rsp_valid_held", rsp_valid, 1);
        chk("rsp_lo_held", rsp_lo, e.lo);
        chk("rsp_zero_held", rsp_zero, e.zero);
        chk("req_ready_low_held", req_ready, 0);
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    chk("req_ready_low_retire_cycle", req_ready, 0);
    @(posedge clk); #1;
    chk("rsp_valid_cleared", rsp_valid, 0);
    chk("busy_cleared", busy, 0);
    chk("req_ready_after_retire", req_ready, 1);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    // op, a, b, alu_result, lo, hi, zero, err, cycles-to-rsp_valid, start, hold, junk
    vecs.push_back(mk(5'b10001, 32'd5, 32'd7, 64'd12, 32'd12, 32'd0, 1'b0, 1'b0, 2, 1'b1, 0, 1'b0));
    vecs.push_back(mk(5'b00000, 32'hF0, 32'h0F, 64'd0, 32'd0, 32'd0, 1'b1, 1'b0, 2, 1'b1, 5, 1'b0));
    vecs.push_back(mk(5'b10100, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 32'd14, 32'd2, 1'b0,
                      1'b0, 35, 1'b1, 0, 1'b1));
    vecs.push_back(mk(5'b01100, 32'd3, 32'd4, 64'h1234, 32'd0, 32'd0, 1'b1, 1'b1, 1, 1'b0, 2,
                      1'b0));
    vecs.push_back(mk(5'b10011, 32'h10000, 32'h10000, 64'h1_0000_0000, 32'd0, 32'd1, 1'b0, 1'b0,
                      3, 1'b1, 0, 1'b0));
    vecs.push_back(mk(5'b11111, 32'd1, 32'd1, 64'h55, 32'd0, 32'd0, 1'b1, 1'b1, 1, 1'b0, 0, 1'b0));
    vecs.push_back(mk(5'b01101, 32'd1, 32'd1, 64'h55, 32'd0, 32'd0, 1'b1, 1'b1, 1, 1'b0, 0, 1'b0));
    vecs.push_back(mk(5'b10101, 32'd1, 32'd1, 64'h55, 32'd0, 32'd0, 1'b1, 1'b1, 1, 1'b0, 0, 1'b0));
    vecs.push_back(mk(5'b01011, 32'd1, 32'd0, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF,
                      32'hFFFF_FFFF, 1'b0, 1'b0, 2, 1'b1, 0, 1'b0));
    vecs.push_back(mk(5'b01110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 32'd0, 32'd0, 1'b1, 1'b0, 2,
                      1'b1, 0, 1'b0));
    vecs.push_back(mk(5'b10010, 32'd10, 32'd3, 64'd7, 32'd7, 32'd0, 1'b0, 1'b0, 2, 1'b1, 1, 1'b0));
`ifdef ALU_SEQ_DIV0_CHK_EN
    vecs.push_back(mk(5'b10100, 32'd9, 32'd0, 64'h77, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 1,
                      1'b0, 0, 1'b0));
`else
    vecs.push_back(mk(5'b10100, 32'd9, 32'd0, 64'h77, 32'h77, 32'd0, 1'b0, 1'b0, 35, 1'b1, 0,
                      1'b0));
`endif

    // Power-on reset.
    repeat (3) @(posedge clk);
    #1;
    chk("reset_alu_a", alu_a, 0);
    chk("reset_alu_opcode", alu_opcode, 0);
    chk("reset_alu_start", alu_start, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_busy", busy, 0);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk); #1;
    chk("req_ready_after_reset", req_ready, 1);
    chk("rsp_valid_after_reset", rsp_valid, 0);

    foreach (vecs[i]) run_op(vecs[i]);

    // Reset in the middle of a MUL discards it.
    @(negedge clk);
    req_valid = 1'b1; req_opcode = 5'b10011; req_a = 32'h10000; req_b = 32'h10000;
    alu_result = 64'h1_0000_0000;
    @(posedge clk); #1;
    chk("mid_reset_start", alu_start, 1);
    chk("mid_reset_busy", busy, 1);
    @(negedge clk);
    req_valid = 1'b0;
    clr = 1'b0;
    @(posedge clk); #1;
    chk("mid_reset_alu_a", alu_a, 0);
    chk("mid_reset_alu_b", alu_b, 0);
    chk("mid_reset_alu_opcode", alu_opcode, 0);
    chk("mid_reset_alu_start", alu_start, 0);
    chk("mid_reset_rsp_valid", rsp_valid, 0);
    chk("mid_reset_rsp_hi_lo", {rsp_hi, rsp_lo}, 0);
    chk("mid_reset_rsp_flags", {rsp_zero, rsp_err}, 0);
    chk("mid_reset_busy_low", busy, 0);
    @(negedge clk);
    clr = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("no_rsp_after_reset", rsp_valid, 0);
      chk("idle_after_reset", req_ready, 1);
    end
    run_op(mk(5'b00101, 32'd0, 32'd0, 64'h0000_0000_FFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0,
              2, 1'b1, 0, 1'b0));

    chk("scoreboard_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
